// File: rtl/avst_pkt_arbiter.sv
// rtl/avst_pkt_arbiter.sv - two-input packet round-robin Avalon-ST arbiter; optional watchdog under ARB_TIMEOUT_EN
module avst_pkt_arbiter #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic [EMPTY_W-1:0] in0_empty,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic [EMPTY_W-1:0] in1_empty,
    input  logic               in1_valid,
    output logic               in1_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         grant,
    output logic               abort,
    output logic               drop
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t             state;
    logic               last;
    logic               can_load, req0, req1, win0, win1, fire;
    logic               acc0, acc1, sel1, load, orphan;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_sop, sel_eop;
    logic [EMPTY_W-1:0] sel_empty;

    if (TIMEOUT < 1 || TIMEOUT > 65535 || (TO_W < 31 && TIMEOUT >= (1 << TO_W))) begin : g_bad_timeout
        $error("avst_pkt_arbiter: TIMEOUT out of range for TO_W");
    end

    assign can_load = !out_valid || out_ready;
    assign req0     = in0_valid && in0_sop;
    assign req1     = in1_valid && in1_sop;
    assign win1     = req1 && (!req0 || !last);
    assign win0     = req0 && !win1;

    // An arbitration loser keeps its sop beat; only orphans are swallowed while idle.
    assign in0_ready = can_load && ((state == IDLE) ? !(req0 && win1) : (state == OWN0 && !fire));
    assign in1_ready = can_load && ((state == IDLE) ? !(req1 && win0) : (state == OWN1 && !fire));
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;

    assign sel1      = (state == OWN1) || (state == IDLE && win1);
    assign sel_data  = sel1 ? in1_data  : in0_data;
    assign sel_sop   = sel1 ? in1_sop   : in0_sop;
    assign sel_eop   = sel1 ? in1_eop   : in0_eop;
    assign sel_empty = sel1 ? in1_empty : in0_empty;
    assign orphan    = (state == IDLE) && ((acc0 && !in0_sop) || (acc1 && !in1_sop));
    assign grant     = {state == OWN1, state == OWN0};

    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:    load = (win0 || win1) && can_load;
            OWN0:    load = acc0;
            OWN1:    load = acc1;
            default: load = 1'b0;
        endcase
        if (fire)
            load = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= orphan;
            if (can_load) begin
                out_valid <= load;
                if (fire) begin
                    out_data  <= '0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b1;
                    out_empty <= '0;
                end else if (load) begin
                    out_data  <= sel_data;
                    out_sop   <= sel_sop;
                    out_eop   <= sel_eop;
                    out_empty <= sel_eop ? sel_empty : '0;
                end
            end
            case (state)
                IDLE: if (load) begin
                    last <= win1;
                    if (!sel_eop)
                        state <= win1 ? OWN1 : OWN0;
                end
                OWN0:    if (fire || (acc0 && in0_eop)) state <= IDLE;
                OWN1:    if (fire || (acc1 && in1_eop)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;
    logic            own_valid;

    assign own_valid = (state == OWN0) ? in0_valid : in1_valid;
    assign fire      = (state != IDLE) && (wd_cnt == TO_W'(TIMEOUT)) && can_load;

    // Counts owner stall cycles only; saturates so a blocked output never wraps it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            abort  <= 1'b0;
        end else begin
            abort <= fire;
            if (state == IDLE || fire || acc0 || acc1)
                wd_cnt <= '0;
            else if (!own_valid && wd_cnt != TO_W'(TIMEOUT))
                wd_cnt <= wd_cnt + TO_W'(1);
        end
    end
`else
    assign fire  = 1'b0;
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// tb/tb_avst_pkt_arbiter.sv - directed vector bench for avst_pkt_arbiter
module tb_avst_pkt_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [7:0] in0_data, in1_data, out_data;
    logic       in0_sop, in0_eop, in0_valid, in0_ready;
    logic       in1_sop, in1_eop, in1_valid, in1_ready;
    logic [1:0] in0_empty, in1_empty, out_empty;
    logic       out_sop, out_eop, out_valid, out_ready;
    logic [1:0] grant;
    logic       abort, drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    avst_pkt_arbiter #(.DATA_W(8), .EMPTY_W(2), .TIMEOUT(4), .TO_W(16)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_sop(in0_sop), .in0_eop(in0_eop), .in0_empty(in0_empty),
        .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_sop(in1_sop), .in1_eop(in1_eop), .in1_empty(in1_empty),
        .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .abort(abort), .drop(drop)
    );

    typedef struct {
        logic v0, s0, e0; logic [1:0] m0; logic [7:0] d0;
        logic v1, s1, e1; logic [1:0] m1; logic [7:0] d1;
        logic ordy;
        logic [1:0] x_rdy;
        logic x_valid, x_sop, x_eop; logic [1:0] x_empty; logic [7:0] x_data;
        logic [1:0] x_grant; logic x_drop;
    } vec_t;

    vec_t tv [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set0(input logic v, input logic s, input logic e, input logic [1:0] m, input logic [7:0] d);
        in0_valid = v; in0_sop = s; in0_eop = e; in0_empty = m; in0_data = d;
    endtask

    task automatic set1(input logic v, input logic s, input logic e, input logic [1:0] m, input logic [7:0] d);
        in1_valid = v; in1_sop = s; in1_eop = e; in1_empty = m; in1_data = d;
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int n;
        logic found;
        tv[0]  = '{H,H,L,2'd0,8'hA0, H,H,L,2'd0,8'hB0, H, 2'b10, H,H,L,2'd0,8'hA0,2'b01,L};
        tv[1]  = '{H,L,L,2'd2,8'hA1, H,H,L,2'd0,8'hB0, H, 2'b10, H,L,L,2'd0,8'hA1,2'b01,L};
        tv[2]  = '{H,L,H,2'd1,8'hA2, H,H,L,2'd0,8'hB0, H, 2'b10, H,L,H,2'd1,8'hA2,2'b00,L};
        tv[3]  = '{L,L,L,2'd0,8'h00, H,H,L,2'd0,8'hB0, H, 2'b11, H,H,L,2'd0,8'hB0,2'b10,L};
        tv[4]  = '{L,L,L,2'd0,8'h00, H,L,L,2'd0,8'hB1, H, 2'b01, H,L,L,2'd0,8'hB1,2'b10,L};
        tv[5]  = '{L,L,L,2'd0,8'h00, H,L,H,2'd3,8'hB2, H, 2'b01, H,L,H,2'd3,8'hB2,2'b00,L};
        tv[6]  = '{L,L,L,2'd0,8'h00, H,H,H,2'd3,8'hC0, H, 2'b11, H,H,H,2'd3,8'hC0,2'b00,L};
        tv[7]  = '{L,L,L,2'd0,8'h00, H,H,H,2'd3,8'hC1, H, 2'b11, H,H,H,2'd3,8'hC1,2'b00,L};
        tv[8]  = '{L,L,L,2'd0,8'h00, H,H,H,2'd3,8'hC2, H, 2'b11, H,H,H,2'd3,8'hC2,2'b00,L};
        tv[9]  = '{H,H,H,2'd0,8'hD0, H,H,H,2'd0,8'hE0, H, 2'b10, H,H,H,2'd0,8'hD0,2'b00,L};
        tv[10] = '{H,H,H,2'd0,8'hD1, H,H,H,2'd0,8'hE0, H, 2'b01, H,H,H,2'd0,8'hE0,2'b00,L};
        tv[11] = '{H,H,H,2'd0,8'hD1, L,L,L,2'd0,8'h00, H, 2'b11, H,H,H,2'd0,8'hD1,2'b00,L};
        tv[12] = '{H,H,L,2'd0,8'hF0, L,L,L,2'd0,8'h00, H, 2'b11, H,H,L,2'd0,8'hF0,2'b01,L};
        tv[13] = '{H,L,L,2'd0,8'hF1, H,H,H,2'd0,8'h60, L, 2'b00, H,H,L,2'd0,8'hF0,2'b01,L};
        tv[14] = '{H,L,L,2'd0,8'hF1, H,H,H,2'd0,8'h60, L, 2'b00, H,H,L,2'd0,8'hF0,2'b01,L};
        tv[15] = '{H,L,L,2'd0,8'hF1, H,H,H,2'd0,8'h60, L, 2'b00, H,H,L,2'd0,8'hF0,2'b01,L};
        tv[16] = '{H,L,L,2'd0,8'hF1, H,H,H,2'd0,8'h60, L, 2'b00, H,H,L,2'd0,8'hF0,2'b01,L};
        tv[17] = '{H,L,L,2'd0,8'hF1, H,H,H,2'd0,8'h60, H, 2'b10, H,L,L,2'd0,8'hF1,2'b01,L};
        tv[18] = '{H,L,H,2'd2,8'hF2, H,H,H,2'd0,8'h60, H, 2'b10, H,L,H,2'd2,8'hF2,2'b00,L};
        tv[19] = '{L,L,L,2'd0,8'h00, H,H,H,2'd0,8'h60, H, 2'b11, H,H,H,2'd0,8'h60,2'b00,L};
        tv[20] = '{H,L,L,2'd0,8'h55, L,L,L,2'd0,8'h00, H, 2'b11, L,L,L,2'd0,8'h00,2'b00,H};
        tv[21] = '{L,L,L,2'd0,8'h00, L,L,L,2'd0,8'h00, H, 2'b11, L,L,L,2'd0,8'h00,2'b00,L};

        rst_n = 1'b0;
        out_ready = 1'b1;
        set0(L, L, L, 2'd0, 8'h00);
        set1(L, L, L, 2'd0, 8'h00);
        repeat (2) tick();
        check("reset_outputs", {out_valid, out_sop, out_eop, out_empty, out_data, grant, abort, drop}, 32'h0);
        check("reset_readies", {in0_ready, in1_ready}, 32'h3);
        @(negedge sys_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge sys_clk);
            set0(tv[i].v0, tv[i].s0, tv[i].e0, tv[i].m0, tv[i].d0);
            set1(tv[i].v1, tv[i].s1, tv[i].e1, tv[i].m1, tv[i].d1);
            out_ready = tv[i].ordy;
            #1;
            check($sformatf("v%0d_ready", i), {in0_ready, in1_ready}, tv[i].x_rdy);
            tick();
            if (tv[i].x_valid)
                check($sformatf("v%0d_out", i),
                      {out_valid, out_sop, out_eop, out_empty, out_data, grant, drop},
                      {tv[i].x_valid, tv[i].x_sop, tv[i].x_eop, tv[i].x_empty, tv[i].x_data, tv[i].x_grant, tv[i].x_drop});
            else
                check($sformatf("v%0d_idle", i), {out_valid, grant, drop},
                      {tv[i].x_valid, tv[i].x_grant, tv[i].x_drop});
        end

        // Stalled owner: in0 opens a packet then goes silent while in1 waits.
        @(negedge sys_clk);
        set0(H, H, L, 2'd0, 8'h90);
        set1(L, L, L, 2'd0, 8'h00);
        tick();
        check("stall_sop", {out_valid, out_sop, out_data, grant}, {1'b1, 1'b1, 8'h90, 2'b01});
        @(negedge sys_clk);
        set0(L, L, L, 2'd0, 8'h00);
        set1(H, H, H, 2'd1, 8'h70);
`ifdef ARB_TIMEOUT_EN
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            tick();
            n++;
            if (out_valid) found = 1'b1;
        end
        check("to_latency", n, 5);
        check("to_beat", {out_valid, out_sop, out_eop, out_empty, out_data, abort, grant},
              {1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 2'b00});
        tick();
        check("to_next_pkt", {out_valid, out_sop, out_eop, out_empty, out_data, abort},
              {1'b1, 1'b1, 1'b1, 2'd1, 8'h70, 1'b0});
        set1(L, L, L, 2'd0, 8'h00);
        set0(H, L, H, 2'd0, 8'h91);
        tick();
        check("to_orphan", {out_valid, drop}, {1'b0, 1'b1});
        set0(L, L, L, 2'd0, 8'h00);
        tick();
`else
        repeat (10) tick();
        check("hold_owner", {out_valid, abort, grant, in1_ready}, {1'b0, 1'b0, 2'b01, 1'b0});
        set0(H, L, H, 2'd2, 8'h91);
        tick();
        check("hold_eop", {out_valid, out_eop, out_empty, out_data, grant}, {1'b1, 1'b1, 2'd2, 8'h91, 2'b00});
        set0(L, L, L, 2'd0, 8'h00);
        tick();
        check("hold_next_pkt", {out_valid, out_sop, out_eop, out_empty, out_data}, {1'b1, 1'b1, 1'b1, 2'd1, 8'h70});
        set1(L, L, L, 2'd0, 8'h00);
        tick();
`endif

        // Reset mid-packet from in0: last returns to 1 so in0 must win the next tie.
        @(negedge sys_clk);
        set0(H, H, L, 2'd0, 8'h30);
        tick();
        check("pre_reset_grant", {out_valid, out_data, grant}, {1'b1, 8'h30, 2'b01});
        @(negedge sys_clk);
        set0(H, L, L, 2'd0, 8'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, out_sop, out_eop, out_empty, out_data, grant, abort, drop}, 32'h0);
        set0(H, H, H, 2'd0, 8'h40);
        set1(H, H, H, 2'd0, 8'h50);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_win0", {out_valid, out_sop, out_data, grant}, {1'b1, 1'b1, 8'h40, 2'b00});
        set0(L, L, L, 2'd0, 8'h00);
        tick();
        check("post_reset_in1", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h50});
        set1(L, L, L, 2'd0, 8'h00);
        tick();
        check("post_reset_idle", {out_valid, grant, drop}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
